instruction_decoder: RTL

Fetch/decode stage that sits directly downstream of the program sequencer and program memory. It registers the instruction word read at pm_addr into ir and decodes it into register load enables, source/ALU selects and an immediate field. It also produces the control inputs the sequencer consumes: jmp, jmp_nz, jmp_addr and dont_jmp. It owns the zero-flag register that qualifies conditional jumps.

---
 rtl/cme341_isa_pkg.sv | 36 +++
 rtl/dst_onehot.sv | 15 +
 rtl/instruction_decoder.sv | 75 +++++++
 3 files changed

// File: rtl/cme341_isa_pkg.sv
// rtl/cme341_isa_pkg.sv - instruction-set constants shared by the decode stage
// Class prefixes, destination codes, source selects and the reset no-op word.
package cme341_isa_pkg;

    localparam int          IMM_W    = 4;
    localparam logic [7:0]  NOP_WORD = 8'h80;

    localparam logic        CLS_LOAD = 1'b0;
    localparam logic [1:0]  CLS_MOVE = 2'b10;
    localparam logic [2:0]  CLS_ALU  = 3'b110;
    localparam logic [3:0]  CLS_JMP  = 4'hE;
    localparam logic [3:0]  CLS_JNZ  = 4'hF;

    localparam logic [2:0]  DST_X0   = 3'd0;
    localparam logic [2:0]  DST_X1   = 3'd1;
    localparam logic [2:0]  DST_Y0   = 3'd2;
    localparam logic [2:0]  DST_LOOP = 3'd3;
    localparam logic [2:0]  DST_M    = 3'd4;
    localparam logic [2:0]  DST_I    = 3'd5;
    localparam logic [2:0]  DST_DM   = 3'd6;
    localparam logic [2:0]  DST_OREG = 3'd7;

    localparam logic [3:0]  SRC_IMM  = 4'd8;

    typedef enum logic [2:0] {
        ALU_NEG  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_MAC  = 3'd3,
        ALU_MUL  = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_AND  = 3'd6,
        ALU_OR   = 3'd7
    } alu_func_e;

endpackage

// File: rtl/dst_onehot.sv
// rtl/dst_onehot.sv - 3-to-8 one-hot destination decoder with enable
module dst_onehot (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);

    always_comb begin
        onehot_o = 8'h00;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - fetch/decode stage: instruction register, decode, zero flag
// Decode is combinational from ir; only ir and the zero flag hold state.
module instruction_decoder
    import cme341_isa_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pm_data,
    input  logic             alu_zero,
    output logic [7:0]       ir,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       jmp_addr,
    output logic             dont_jmp,
    output logic [IMM_W-1:0] imm,
    output logic [7:0]       ld_en,
    output logic [3:0]       src_sel,
    output logic [2:0]       alu_func,
    output logic             x_sel,
    output logic             y_sel,
    output logic             alu_en
);

    logic [7:0] ir_q, ir_d;
    logic       zero_q, zero_d;
    logic       is_load, is_move, is_alu, move_live;
    logic [2:0] dst;

    assign ir_d   = pm_data;
    assign zero_d = alu_en ? alu_zero : zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q   <= NOP_WORD;
            zero_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            zero_q <= zero_d;
        end
    end

    assign is_load   = (ir_q[7]   == CLS_LOAD);
    assign is_move   = (ir_q[7:6] == CLS_MOVE);
    assign is_alu    = (ir_q[7:5] == CLS_ALU);
    // A move onto its own source is the no-op encoding and must not load.
    assign move_live = is_move && (ir_q[5:3] != ir_q[2:0]);
    assign dst       = is_load ? ir_q[6:4] : ir_q[5:3];

    dst_onehot u_dst_onehot (
        .en_i     (is_load | move_live),
        .sel_i    (dst),
        .onehot_o (ld_en)
    );

    always_comb begin
        src_sel = 4'd0;
        if (is_load) begin
            src_sel = SRC_IMM;
        end else if (move_live) begin
            src_sel = {1'b0, ir_q[2:0]};
        end
    end

    assign alu_en   = is_alu;
    assign alu_func = is_alu ? ir_q[4:2] : 3'd0;
    assign x_sel    = is_alu & ir_q[1];
    assign y_sel    = is_alu & ir_q[0];
    assign jmp      = (ir_q[7:4] == CLS_JMP);
    assign jmp_nz   = (ir_q[7:4] == CLS_JNZ);
    assign jmp_addr = ir_q[3:0];
    assign imm      = ir_q[IMM_W-1:0];
    assign ir       = ir_q;
    assign dont_jmp = zero_q;

endmodule
